// File: rtl/carfield_eoc_monitor.sv
// End-of-computation monitor: snoops the EOC scratch register write,
// latches the exit code and enforces an optional run-time watchdog.
module carfield_eoc_monitor #(
  parameter int unsigned          AddrWidth     = 48,
  parameter logic [AddrWidth-1:0] EocAddr       = 48'h0300_0008,
  parameter logic [31:0]          TimeoutCycles = 32'd0,
  parameter int unsigned          CntWidth      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 clear_i,
  input  logic                 bus_req_i,
  input  logic                 bus_we_i,
  input  logic [AddrWidth-1:0] bus_addr_i,
  input  logic [31:0]          bus_wdata_i,
  input  logic                 bus_gnt_i,
  output logic                 busy_o,
  output logic                 eoc_o,
  output logic                 timeout_o,
  output logic [31:0]          exit_code_o,
  output logic [CntWidth-1:0]  cycles_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUNNING = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  localparam logic [1:0] TIMEOUT = 2'd3;

  localparam logic TimerEn = (TimeoutCycles != 32'd0);
  localparam logic [CntWidth-1:0] Limit =
    CntWidth'(TimeoutCycles - 32'd1);

  logic [1:0]          state_q;
  logic [31:0]         exit_q;
  logic [CntWidth-1:0] cycles_q;
  logic                addr_hit;
  logic                hit;
  logic                expire;

  assign addr_hit = bus_addr_i[AddrWidth-1:2] == EocAddr[AddrWidth-1:2];
  assign hit = bus_req_i & bus_gnt_i & bus_we_i
             & addr_hit & bus_wdata_i[0];
  assign expire = TimerEn && (cycles_q == Limit);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q  <= IDLE;
      exit_q   <= '0;
      cycles_q <= '0;
    end else begin
      unique case (1'b1)
        state_q == IDLE: begin
          if (start_i) begin
            state_q  <= RUNNING;
            cycles_q <= '0;
          end
        end
        state_q == RUNNING: begin
          if (cycles_q != '1) cycles_q <= cycles_q + 1'b1;
          // A hit on the expiry cycle still counts as a clean finish.
          if (hit) begin
            state_q <= DONE;
            exit_q  <= {1'b0, bus_wdata_i[31:1]};
          end else if (expire) begin
            state_q <= TIMEOUT;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy_o      = state_q == RUNNING;
  assign eoc_o       = state_q == DONE;
  assign timeout_o   = state_q == TIMEOUT;
  assign exit_code_o = exit_q;
  assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_carfield_eoc_monitor.sv
// Directed bench for carfield_eoc_monitor: three instances share stimulus
// (no watchdog, 50-cycle watchdog, 4-bit saturating counter).
module tb_carfield_eoc_monitor;

  localparam logic [47:0] EOC = 48'h0300_0008;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        gnt = 1'b0;
  logic [47:0] addr = '0;
  logic [31:0] wdata = '0;

  logic        busy0, eoc0, to0;
  logic [31:0] exit0, cyc0;
  logic        busy1, eoc1, to1;
  logic [31:0] exit1, cyc1;
  logic        busy2, eoc2, to2;
  logic [31:0] exit2;
  logic [3:0]  cyc2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  carfield_eoc_monitor #(.TimeoutCycles(32'd0)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
    .bus_req_i(req), .bus_we_i(we), .bus_addr_i(addr),
    .bus_wdata_i(wdata), .bus_gnt_i(gnt),
    .busy_o(busy0), .eoc_o(eoc0), .timeout_o(to0),
    .exit_code_o(exit0), .cycles_o(cyc0)
  );

  carfield_eoc_monitor #(.TimeoutCycles(32'd50)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
    .bus_req_i(req), .bus_we_i(we), .bus_addr_i(addr),
    .bus_wdata_i(wdata), .bus_gnt_i(gnt),
    .busy_o(busy1), .eoc_o(eoc1), .timeout_o(to1),
    .exit_code_o(exit1), .cycles_o(cyc1)
  );

  carfield_eoc_monitor #(.CntWidth(4)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
    .bus_req_i(req), .bus_we_i(we), .bus_addr_i(addr),
    .bus_wdata_i(wdata), .bus_gnt_i(gnt),
    .busy_o(busy2), .eoc_o(eoc2), .timeout_o(to2),
    .exit_code_o(exit2), .cycles_o(cyc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic r, input logic w, input logic g,
                     input logic [47:0] a, input logic [31:0] d);
    req = r; we = w; gnt = g; addr = a; wdata = d;
  endtask

  task automatic bus_idle();
    bus(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_eoc", 32'(eoc0), 32'd0);
    chk("rst_to", 32'(to0), 32'd0);
    chk("rst_exit", exit0, 32'd0);
    chk("rst_cyc", cyc0, 32'd0);

    // hit before start is ignored
    bus(1'b1, 1'b1, 1'b1, EOC, 32'h1); step(); bus_idle();
    chk("idle_hit_eoc", 32'(eoc0), 32'd0);
    chk("idle_hit_busy", 32'(busy0), 32'd0);

    // run 1: non-hits, stray start, then hit on the 100th cycle
    pulse_start();
    chk("run1_busy", 32'(busy0), 32'd1);
    chk("run1_cyc0", cyc0, 32'd0);
    for (int i = 0; i < 99; i++) begin
      bus_idle();
      start = 1'b0;
      case (i)
        10: bus(1'b1, 1'b1, 1'b1, EOC, 32'hFFFF_FFFE);
        11: bus(1'b1, 1'b0, 1'b1, EOC, 32'h1);
        12: bus(1'b1, 1'b1, 1'b1, EOC + 48'd4, 32'h1);
        13: bus(1'b1, 1'b1, 1'b0, EOC, 32'h1);
        20: start = 1'b1;
        default: ;
      endcase
      step();
    end
    bus_idle();
    start = 1'b0;
    chk("nohit_busy", 32'(busy0), 32'd1);
    chk("nohit_eoc", 32'(eoc0), 32'd0);
    chk("nohit_cyc", cyc0, 32'd99);
    chk("sat_cyc", 32'(cyc2), 32'd15);
    chk("wd_to", 32'(to1), 32'd1);
    chk("wd_cyc", cyc1, 32'd50);
    bus(1'b1, 1'b1, 1'b1, EOC, 32'h1); step(); bus_idle();
    chk("hit1_eoc", 32'(eoc0), 32'd1);
    chk("hit1_exit", exit0, 32'd0);
    chk("hit1_busy", 32'(busy0), 32'd0);
    chk("hit1_cyc", cyc0, 32'd100);
    chk("hit1_to", 32'(to0), 32'd0);
    step(); step();
    chk("done_frozen", cyc0, 32'd100);
    chk("sat_frozen", 32'(cyc2), 32'd15);

    pulse_clear();
    chk("clr_eoc", 32'(eoc0), 32'd0);
    chk("clr_cyc", cyc0, 32'd0);
    chk("clr_busy", 32'(busy0), 32'd0);
    chk("clr_to1", 32'(to1), 32'd0);

    // run 2: exit code 3, later write ignored
    pulse_start();
    bus(1'b1, 1'b1, 1'b1, EOC, 32'h7); step(); bus_idle();
    chk("hit2_eoc", 32'(eoc0), 32'd1);
    chk("hit2_exit", exit0, 32'd3);
    bus(1'b1, 1'b1, 1'b1, EOC, 32'h5); step(); bus_idle();
    chk("late_exit", exit0, 32'd3);
    pulse_clear();
    chk("clr2_exit", exit0, 32'd0);

    // watchdog expiry, 50 cycles after busy rose
    pulse_start();
    repeat (49) step();
    chk("wd49_to", 32'(to1), 32'd0);
    chk("wd49_busy", 32'(busy1), 32'd1);
    chk("wd49_cyc", cyc1, 32'd49);
    step();
    chk("wd50_to", 32'(to1), 32'd1);
    chk("wd50_cyc", cyc1, 32'd50);
    chk("wd50_eoc", 32'(eoc1), 32'd0);
    chk("wd50_exit", exit1, 32'd0);
    chk("nowd_busy", 32'(busy0), 32'd1);
    pulse_clear();

    // hit on the expiry cycle wins
    pulse_start();
    repeat (49) step();
    bus(1'b1, 1'b1, 1'b1, EOC, 32'h9); step(); bus_idle();
    chk("race_eoc", 32'(eoc1), 32'd1);
    chk("race_to", 32'(to1), 32'd0);
    chk("race_exit", exit1, 32'd4);
    chk("race_cyc", cyc1, 32'd50);
    pulse_clear();

    // reset mid-run
    pulse_start();
    repeat (5) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("mrst_busy", 32'(busy0), 32'd0);
    chk("mrst_eoc", 32'(eoc0), 32'd0);
    chk("mrst_cyc", cyc0, 32'd0);
    chk("mrst_exit", exit0, 32'd0);

    // start and clear together stay idle
    start = 1'b1; clear = 1'b1; step();
    start = 1'b0; clear = 1'b0;
    chk("sc_busy", 32'(busy0), 32'd0);
    step();
    chk("sc_busy2", 32'(busy0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
